// File: rtl/full_adder_unit_half_adder.sv
// Half adder cell: sum and carry of two single-bit inputs.
module full_adder_unit_half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/full_adder_unit.sv
// Ripple-carry adder of WIDTH full-adder cells, each cell two half adders plus an OR.
// Optional single output register stage with valid tracking.
module full_adder_unit #(
  parameter int unsigned WIDTH        = 1,
  parameter bit          REGISTER_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             z,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = z;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic prop;
    logic gen_xy;
    logic gen_cin;

    full_adder_unit_half_adder u_ha_xy (
      .a (x[i]),
      .b (y[i]),
      .s (prop),
      .c (gen_xy)
    );

    full_adder_unit_half_adder u_ha_cin (
      .a (prop),
      .b (carry[i]),
      .s (sum_comb[i]),
      .c (gen_cin)
    );

    assign carry[i+1] = gen_xy | gen_cin;
  end

  if (REGISTER_OUT) begin : g_reg
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             valid_q, valid_d;

    // Capture a new result only on valid input; otherwise hold data and drop valid.
    always_comb begin
      s_d     = s_q;
      c_d     = c_q;
      valid_d = in_valid;
      if (in_valid) begin
        s_d = sum_comb;
        c_d = carry[WIDTH];
      end
    end

    // Output register; reset clears results immediately, independent of clk.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q     <= '0;
        c_q     <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        s_q     <= s_d;
        c_q     <= c_d;
        valid_q <= valid_d;
      end
    end

    assign s         = s_q;
    assign c         = c_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    // Clock and reset have no role in the combinational configuration.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign s         = sum_comb;
    assign c         = carry[WIDTH];
    assign out_valid = in_valid;
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit in combinational and registered configurations.
module tb_full_adder_unit;

  int n_cmp  = 0;
  int n_fail = 0;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // WIDTH=1 combinational; inputs left undriven at time 0 on purpose.
  logic x1, y1, z1;
  logic iv1 = 1'b1;
  logic s1, c1, ov1;

  // WIDTH=8 combinational.
  logic [7:0] x8 = '0, y8 = '0;
  logic       z8 = 1'b0;
  logic       iv8 = 1'b1;
  logic [7:0] s8;
  logic       c8, ov8;

  // WIDTH=16 combinational.
  logic [15:0] xa = '0, ya = '0;
  logic        za = 1'b0, iva = 1'b0;
  logic [15:0] sa;
  logic        ca, ova;

  // WIDTH=1 registered.
  logic rx1 = 1'b0, ry1 = 1'b0, rz1 = 1'b0, riv1 = 1'b0;
  logic rs1, rc1, rov1;

  // WIDTH=16 registered.
  logic [15:0] rx = '0, ry = '0;
  logic        rz = 1'b0, riv = 1'b0;
  logic [15:0] rs;
  logic        rc, rov;

  full_adder_unit #(.WIDTH(1), .REGISTER_OUT(1'b0)) u_c1 (
    .clk (clk), .rst (rst), .x (x1), .y (y1), .z (z1), .in_valid (iv1),
    .s (s1), .c (c1), .out_valid (ov1)
  );

  full_adder_unit #(.WIDTH(8), .REGISTER_OUT(1'b0)) u_c8 (
    .clk (clk), .rst (rst), .x (x8), .y (y8), .z (z8), .in_valid (iv8),
    .s (s8), .c (c8), .out_valid (ov8)
  );

  full_adder_unit #(.WIDTH(16), .REGISTER_OUT(1'b0)) u_c16 (
    .clk (clk), .rst (rst), .x (xa), .y (ya), .z (za), .in_valid (iva),
    .s (sa), .c (ca), .out_valid (ova)
  );

  full_adder_unit #(.WIDTH(1), .REGISTER_OUT(1'b1)) u_r1 (
    .clk (clk), .rst (rst), .x (rx1), .y (ry1), .z (rz1), .in_valid (riv1),
    .s (rs1), .c (rc1), .out_valid (rov1)
  );

  full_adder_unit #(.WIDTH(16), .REGISTER_OUT(1'b1)) u_r16 (
    .clk (clk), .rst (rst), .x (rx), .y (ry), .z (rz), .in_valid (riv),
    .s (rs), .c (rc), .out_valid (rov)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: full-width sum of the three addends.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci);
    return {1'b0, a} + {1'b0, b} + {16'd0, ci};
  endfunction

  // Expected {c,s} for vector {x,y,z} = 0..7.
  logic [1:0] tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  logic [16:0] r;
  logic [15:0] m_s;
  logic        m_c, m_v;
  logic [1:0]  prev;

  initial begin
    rst = 1'b1;
    #1;
    chk("x_prop_s", {63'd0, s1}, {63'd0, 1'bx});
    chk("x_prop_c", {63'd0, c1}, {63'd0, 1'bx});
    chk("rst_state_r1", {61'd0, rs1, rc1, rov1}, 64'd0);
    chk("rst_state_r16", {46'd0, rs, rc, rov}, 64'd0);

    // Exhaustive 1-bit combinational, one vector every 50 time units.
    for (int i = 0; i < 8; i++) begin
      {x1, y1, z1} = 3'(i);
      #1;
      chk($sformatf("exh1_%0d", i), {62'd0, c1, s1}, {62'd0, tbl[i]});
      chk($sformatf("exh1_ov_%0d", i), {63'd0, ov1}, 64'd1);
      #49;
    end

    // WIDTH=8 directed cases.
    x8 = 8'hFF; y8 = 8'h00; z8 = 1'b1; #1;
    chk("w8_ff_00_1", {55'd0, c8, s8}, {55'd0, 1'b1, 8'h00});
    x8 = 8'h5A; y8 = 8'hA5; z8 = 1'b0; #1;
    chk("w8_5a_a5_0", {55'd0, c8, s8}, {55'd0, 1'b0, 8'hFF});
    x8 = 8'hFF; y8 = 8'hFF; z8 = 1'b1; #1;
    chk("w8_ff_ff_1", {55'd0, c8, s8}, {55'd0, 1'b1, 8'hFF});

    // Release reset between clock edges.
    @(negedge clk);
    rst = 1'b0;

    // Registered 1-bit streaming with in_valid held high.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("strm_%0d", i - 1), {61'd0, rc1, rs1, rov1}, {61'd0, tbl[i-1], 1'b1});
      end
      riv1 = 1'b1;
      {rx1, ry1, rz1} = 3'(i);
    end
    @(negedge clk);
    chk("strm_7", {61'd0, rc1, rs1, rov1}, {61'd0, tbl[7], 1'b1});
    prev = tbl[7];
    riv1 = 1'b0;
    {rx1, ry1, rz1} = 3'b000;
    @(negedge clk);
    chk("strm_drop", {61'd0, rc1, rs1, rov1}, {61'd0, prev, 1'b0});

    // Reset asserted mid-cycle while holding a valid 1,1 result.
    riv1 = 1'b1;
    {rx1, ry1, rz1} = 3'b111;
    @(negedge clk);
    chk("pre_rst", {61'd0, rs1, rc1, rov1}, 64'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", {61'd0, rs1, rc1, rov1}, 64'd0);
    @(posedge clk);
    #1;
    chk("rst_wins_edge", {61'd0, rs1, rc1, rov1}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    {rx1, ry1, rz1} = 3'b100;
    @(negedge clk);
    chk("post_rst", {61'd0, rs1, rc1, rov1}, {61'd0, 1'b1, 1'b0, 1'b1});
    riv1 = 1'b0;

    // Random combinational WIDTH=16.
    for (int k = 0; k < 1000; k++) begin
      xa  = 16'($urandom);
      ya  = 16'($urandom);
      za  = 1'($urandom);
      iva = 1'($urandom);
      #1;
      r = ref_add(xa, ya, za);
      chk("rnd_comb", {47'd0, ca, sa}, {47'd0, r});
      chk("rnd_comb_ov", {63'd0, ova}, {63'd0, iva});
    end

    // Random registered WIDTH=16; the unit has seen only idle cycles since reset.
    m_s = '0;
    m_c = 1'b0;
    m_v = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      chk("rnd_reg", {46'd0, rc, rs, rov}, {46'd0, m_c, m_s, m_v});
      rx  = 16'($urandom);
      ry  = 16'($urandom);
      rz  = 1'($urandom);
      riv = ($urandom_range(3) != 0);
      if (riv) begin
        r = ref_add(rx, ry, rz);
        {m_c, m_s} = r;
      end
      m_v = riv;
    end
    @(negedge clk);
    chk("rnd_reg_last", {46'd0, rc, rs, rov}, {46'd0, m_c, m_s, m_v});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/full_adder_unit.md
Name: full_adder_unit

Overview:
- Ripple-carry adder built from 1-bit full-adder cells. Each cell is two half adders plus an OR.
- Adds operands x and y with carry-in z, producing sum s and carry-out c.
- Default configuration (WIDTH=1, REGISTER_OUT=0) is a purely combinational 1-bit full adder.
- Optional output register stage with valid tracking is provided for use inside clocked datapaths.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1 to 64).
- REGISTER_OUT, 0, 0 = combinational outputs; 1 = outputs registered with one cycle of latency.

Ports:
- clk  input  1  clock; used only when REGISTER_OUT=1.
- rst  input  1  asynchronous, active-high reset; used only when REGISTER_OUT=1.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- z  input  1  carry-in.
- in_valid  input  1  marks x/y/z as a valid operation; ignored when REGISTER_OUT=0.
- s  output  WIDTH  sum.
- c  output  1  carry-out.
- out_valid  output  1  marks s/c as valid; when REGISTER_OUT=0, it equals in_valid.

Behaviour:
- Arithmetic: {c, s} = x + y + z, computed at WIDTH+1 bits with no truncation. No overflow flag; c is the only overflow indication.
- Per-bit cell, bit i:
  - s_i = x_i ^ y_i ^ cin_i
  - cout_i = (x_i & y_i) | (cin_i & (x_i ^ y_i))
  - cin_0 = z; cin_{i+1} = cout_i; c = cout_{WIDTH-1}.
- REGISTER_OUT=0:
  - Outputs are purely combinational and settle within the same delta/time step as the input change.
  - No state; clk and rst have no effect.
  - Outputs are X while any input is X or Z. No X-masking.
- REGISTER_OUT=1:
  - On rising clk with in_valid=1: s and c capture that cycle's sum, and out_valid goes to 1. Latency is exactly one cycle.
  - On rising clk with in_valid=0: s and c hold their previous values, and out_valid goes to 0.
  - Back-to-back in_valid=1 gives one result per cycle. There is no backpressure and no ready signal.
  - Reset: while rst=1, s=0, c=0 and out_valid=0, asynchronously and immediately, independent of clk.
  - Reset deasserted mid-stream: the first capture happens on the first rising clk after deassertion. Operations in flight during reset are dropped.
  - rst and a clk edge together: rst wins.
- Boundaries, shown for WIDTH=1:
  - All ones: x=1, y=1, z=1 gives s=1, c=1.
  - All zeros gives s=0, c=0.
  - For any WIDTH, x = y = 2^WIDTH−1 with z=1 gives s = 2^WIDTH−1 and c=1.

Decomposition:
- No shared package is needed. WIDTH is the only configuration item, and it is passed as a parameter.
- One natural sub-module: half_adder, with inputs a, b and outputs s = a^b, c = a&b.
- Each full-adder bit is two half_adder instances plus an OR of their carries.
- Bits are generated with a generate loop. The register stage is a single always block with async reset.

Test Plan:
- Exhaustive 1-bit, REGISTER_OUT=0: step x,y,z through 000..111, one vector every 50 time units.
  - Required (s,c) in order: (0,0) (1,0) (1,0) (0,1) (1,0) (0,1) (0,1) (1,1).
- X propagation: at time 0 with x, y, z undriven, s and c must read x. They must resolve to (0,0) once 000 is applied.
- WIDTH=8, REGISTER_OUT=0, three cases:
  - x=0xFF, y=0x00, z=1 → s=0x00, c=1.
  - x=0x5A, y=0xA5, z=0 → s=0xFF, c=0.
  - x=0xFF, y=0xFF, z=1 → s=0xFF, c=1.
- REGISTER_OUT=1, WIDTH=1, streaming:
  - Hold in_valid=1 and apply the 8 vectors above on consecutive clocks.
  - Each (s,c) appears exactly one clock later, with out_valid=1 throughout.
  - Drop in_valid to 0 → out_valid=0 next clock, and s/c hold.
- REGISTER_OUT=1, reset:
  - With out_valid=1 and s=1,c=1, assert rst between clock edges.
  - s, c and out_valid go to 0 immediately.
  - Release rst; the next valid input appears after one clock.
- Random: 1000 random vectors at WIDTH=16 in both modes, checked against a {c,s} = x+y+z reference model.
